// File: rtl/frame_scanout_if.sv
// Frame-buffer read port: registered address and read strobe out, read data back RD_LAT cycles later.
interface frame_scanout_if #(
    parameter int ADDR_W = 20,
    parameter int PIX_W  = 8
);
    logic [ADDR_W-1:0] frame_rdAddress;
    logic              rd_en;
    logic [PIX_W-1:0]  frame_output;

    modport master (output frame_rdAddress, output rd_en, input frame_output);
    modport slave  (input frame_rdAddress, input rd_en, output frame_output);
endinterface

// File: rtl/frame_scanout.sv
// Double-buffered frame-buffer scanout: raster coordinate to read address, read-latency-aligned colour
// expansion, and a vblank-synchronised front/back buffer swap.
module frame_scanout #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter int          SCALE    = 1,
    parameter int          PIX_W    = 8,
    parameter int          ADDR_W   = 20,
    parameter int          RD_LAT   = 1,
    parameter int unsigned BASE0    = 0,
    parameter int unsigned BASE1    = 307200,
    parameter int          MODE     = 0
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              pixel_en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              Display,
    frame_scanout_if.master   fb,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_sel,
    output logic [ADDR_W-1:0] back_base,
    output logic              frame_start,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue
);
    localparam int unsigned       SHIFT   = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
    localparam int unsigned       LINE_W  = H_ACTIVE >> SHIFT;
    localparam logic [ADDR_W-1:0] LINE_A  = ADDR_W'(LINE_W);
    localparam logic [ADDR_W-1:0] BASE0_A = ADDR_W'(BASE0);
    localparam logic [ADDR_W-1:0] BASE1_A = ADDR_W'(BASE1);
    localparam logic [10:0]       H_LIM   = 11'(H_ACTIVE);
    localparam logic [10:0]       V_LIM   = 11'(V_ACTIVE);

    typedef enum logic {IDLE, PENDING} swap_state_t;

    swap_state_t       r_state;
    logic              r_front_sel;
    logic              r_swap_ack;
    logic [ADDR_W-1:0] r_back_base;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_en;
    logic              r_frame_start;
    logic [RD_LAT:0]   r_tag_vld;
    logic [RD_LAT:0]   r_tag_act;
    logic [7:0]        r_red;
    logic [7:0]        r_green;
    logic [7:0]        r_blue;

    logic              w_active;
    logic              w_vblank_start;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_c;
    logic [7:0]        w_r;
    logic [7:0]        w_g;
    logic [7:0]        w_b;

    assign w_active       = pixel_en && Display && ({1'b0, DrawX} < H_LIM) && ({1'b0, DrawY} < V_LIM);
    assign w_vblank_start = pixel_en && ({1'b0, DrawY} == V_LIM) && (DrawX == '0);

    // Power-of-two scale factors make the divide a shift; the sum wraps naturally at ADDR_W bits.
    assign w_base = r_front_sel ? BASE1_A : BASE0_A;
    assign w_row  = ADDR_W'(DrawY >> SHIFT);
    assign w_col  = ADDR_W'(DrawX >> SHIFT);
    assign w_addr = w_base + w_row * LINE_A + w_col;

    assign w_c = fb.frame_output[7:0];

    always_comb begin
        w_r = w_c;
        w_g = w_c;
        w_b = w_c;
        if (MODE == 0) begin
            w_r = {w_c[7:5], w_c[7:5], w_c[7:6]};
            w_g = {w_c[4:2], w_c[4:2], w_c[4:3]};
            w_b = {w_c[1:0], w_c[1:0], w_c[1:0], w_c[1:0]};
        end
    end

    // The tag pipeline shifts every clock so output timing is independent of pixel_en spacing.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr        <= BASE0_A;
            r_rd_en       <= 1'b0;
            r_frame_start <= 1'b0;
            r_tag_vld     <= '0;
            r_tag_act     <= '0;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
        end else begin
            r_rd_en       <= w_active;
            r_frame_start <= pixel_en && (DrawX == '0) && (DrawY == '0);
            r_tag_vld     <= {r_tag_vld[RD_LAT-1:0], pixel_en};
            r_tag_act     <= {r_tag_act[RD_LAT-1:0], w_active};
            if (w_active) begin
                r_addr <= w_addr;
            end
            if (r_tag_vld[RD_LAT]) begin
                if (r_tag_act[RD_LAT]) begin
                    r_red   <= w_r;
                    r_green <= w_g;
                    r_blue  <= w_b;
                end else begin
                    r_red   <= '0;
                    r_green <= '0;
                    r_blue  <= '0;
                end
            end
        end
    end

    // Leaving PENDING ignores swap_req, so a request still high during the swap is consumed by it.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_front_sel <= 1'b0;
            r_swap_ack  <= 1'b0;
            r_back_base <= BASE1_A;
        end else begin
            r_swap_ack  <= 1'b0;
            r_back_base <= r_front_sel ? BASE0_A : BASE1_A;
            case (r_state)
                IDLE: begin
                    if (swap_req) begin
                        r_state <= PENDING;
                    end
                end
                PENDING: begin
                    if (w_vblank_start) begin
                        r_state     <= IDLE;
                        r_front_sel <= ~r_front_sel;
                        r_swap_ack  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fb.frame_rdAddress = r_addr;
    assign fb.rd_en           = r_rd_en;
    assign swap_ack           = r_swap_ack;
    assign front_sel          = r_front_sel;
    assign back_base          = r_back_base;
    assign frame_start        = r_frame_start;
    assign Red                = r_red;
    assign Green              = r_green;
    assign Blue               = r_blue;
endmodule

// File: doc/frame_scanout.md
FRAME_SCANOUT -- requirements
Module: frame_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter SCALE, default 1, pixel replication factor; legal values 1, 2, 4.
REQ-004 SHALL have parameter PIX_W, default 8, frame-buffer word width.
REQ-005 SHALL have parameter ADDR_W, default 20, read-address width.
REQ-006 SHALL have parameter RD_LAT, default 1, frame-buffer read latency in Clk cycles; legal values 1, 2.
REQ-007 SHALL have parameter BASE0, default 0, word address of buffer 0.
REQ-008 SHALL have parameter BASE1, default 307200, word address of buffer 1.
REQ-009 SHALL have parameter MODE, default 0, colour mode: 0 = RGB332, 1 = grayscale.
REQ-010 SHALL have port Clk, input, 1, sole clock.
REQ-011 SHALL have port reset_n, input, 1, one clock; reset is asynchronous and active-low.
REQ-012 SHALL have port pixel_en, input, 1, one-Clk strobe per pixel, from the VGA timing block.
REQ-013 SHALL have ports DrawX and DrawY, input, 10 each, current raster coordinate.
REQ-014 SHALL have port Display, input, 1, high = active video.
REQ-015 SHALL have ports frame_rdAddress (output, ADDR_W), rd_en (output, 1) and frame_output (input, PIX_W).
REQ-016 SHALL have port swap_req, input, 1, level request to exchange front and back buffers.
REQ-017 SHALL have outputs swap_ack (1), front_sel (1), back_base (ADDR_W) and frame_start (1).
REQ-018 SHALL have outputs Red, Green and Blue, 8 each.

Function
REQ-019 Active pixel: pixel_en=1, Display=1, DrawX<H_ACTIVE and DrawY<V_ACTIVE.
REQ-020 On an active pixel, frame_rdAddress SHALL be registered as base + (DrawY/SCALE)*(H_ACTIVE/SCALE) + DrawX/SCALE, and rd_en SHALL pulse for 1 cycle.
- base = front_sel ? BASE1 : BASE0.
- Division by SCALE SHALL be a right shift; the sum SHALL wrap modulo 2^ADDR_W.
REQ-021 On a non-active pixel_en cycle, rd_en SHALL stay 0 and frame_rdAddress SHALL hold.
REQ-022 A valid/blank tag SHALL travel through a pipeline of RD_LAT+1 stages alongside each request.
REQ-023 Red/Green/Blue SHALL update exactly RD_LAT+1 Clk cycles after the pixel_en cycle that was sampled, and SHALL hold until the next update.
REQ-024 A blank tag SHALL produce 0,0,0.
REQ-025 With MODE=0 and c = frame_output[7:0]:
- Red = {c[7:5],c[7:5],c[7:6]}
- Green = {c[4:2],c[4:2],c[4:3]}
- Blue = {c[1:0],c[1:0],c[1:0],c[1:0]}
REQ-026 With MODE=1, Red = Green = Blue = frame_output[7:0].
REQ-027 Swap FSM SHALL have two states, IDLE and PENDING.
- IDLE -> PENDING when swap_req=1.
- PENDING -> IDLE on the first pixel_en cycle with DrawY==V_ACTIVE and DrawX==0 (start of vblank).
- On that PENDING -> IDLE transition, front_sel SHALL toggle and swap_ack SHALL pulse for 1 cycle.
REQ-028 A swap_req that is high in the swap cycle SHALL be absorbed by that swap; a new PENDING needs swap_req=1 after swap_ack.
REQ-029 front_sel SHALL never change outside the swap cycle, so no frame mixes buffers.
REQ-030 back_base SHALL equal front_sel ? BASE0 : BASE1, registered, and SHALL update in the cycle after the toggle.
REQ-031 frame_start SHALL pulse for 1 cycle on pixel_en with DrawX==0 and DrawY==0.
REQ-032 Changing pixel_en spacing SHALL NOT break the pipeline; the minimum spacing is 1 Clk.

Reset
REQ-033 While reset_n=0, asynchronously:
- frame_rdAddress=BASE0, rd_en=0, front_sel=0, back_base=BASE1, swap_ack=0, frame_start=0.
- Red/Green/Blue=0, all pipeline tags blank, FSM=IDLE.
REQ-034 Reset asserted mid-frame or mid-pending SHALL discard the pending swap and in-flight pixels.
REQ-035 After reset_n rises, the first active pixel SHALL read from buffer 0.

Verification
REQ-036 SCALE=2, front_sel=0, DrawX=5, DrawY=3, active -> frame_rdAddress=322 with a single rd_en pulse.
REQ-037 Same coordinate after one swap, BASE1=307200 -> frame_rdAddress=307522.
REQ-038 RD_LAT=2, MODE=0, frame_output=8'hE3 -> RGB = FF,00,FF exactly 3 Clk after pixel_en; Display=0 at the same point -> 00,00,00.
REQ-039 swap_req pulsed at DrawY=100 -> swap_ack and front_sel toggle only at DrawY=480, DrawX=0; back_base=BASE0 one cycle later.
REQ-040 swap_req held high across the swap cycle, then dropped -> exactly one toggle.
REQ-041 reset_n low while PENDING at DrawY=300 -> front_sel stays 0 through the next vblank; all outputs are at their reset values.
